// File: rtl/winner_scan.sv
// ---------------------------------------------------------------------------
// winner_scan
//   Sequential winner-selection engine. On start it snapshots all candidate
//   tallies, then walks them one candidate per clock while keeping a running
//   maximum. It reports the winning index, its count and a tie flag.
//
// Ports
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   start       : scan request, sampled only while idle
//   tally       : packed tallies, candidate k at tally[k*CNT_W +: CNT_W]
//   busy        : high while scanning or presenting the result
//   done        : one-cycle pulse when results become valid
//   winner_idx  : index of the highest tally (lowest index wins ties)
//   winner_cnt  : highest tally value
//   tie         : another candidate equals the winning count
//
// Configuration macro
//   WINNER_SCAN_TIE_EN : when defined, tie detection is built. When
//                        undefined, the tie register and equality logic are
//                        omitted and tie is held at 0.
// ---------------------------------------------------------------------------
module winner_scan #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 4,
    parameter int IDX_W    = $clog2(NUM_CAND)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [NUM_CAND*CNT_W-1:0] tally,
    output logic                      busy,
    output logic                      done,
    output logic [IDX_W-1:0]          winner_idx,
    output logic [CNT_W-1:0]          winner_cnt,
    output logic                      tie
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(NUM_CAND - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   snap_q [NUM_CAND];
    logic [CNT_W-1:0]   snap_d [NUM_CAND];
    logic [CNT_W-1:0]   best_cnt_q, best_cnt_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [IDX_W-1:0]   winner_idx_q, winner_idx_d;
    logic [CNT_W-1:0]   winner_cnt_q, winner_cnt_d;
`ifdef WINNER_SCAN_TIE_EN
    logic               tie_r_q, tie_r_d;
    logic               tie_q, tie_d;
    logic               tie_next;
`endif

    // Unpacked view of the live tally bus.
    logic [CNT_W-1:0]   tally_arr [NUM_CAND];

    generate
        for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_unpack
            assign tally_arr[gi] = tally[gi*CNT_W +: CNT_W];
        end
    endgenerate

    // Result of comparing the current candidate against the running best.
    // Used both to update the running state and, on the last candidate, to
    // load the outputs on the same edge that enters DONE.
    logic [CNT_W-1:0]   cur_cnt;
    logic [CNT_W-1:0]   best_cnt_next;
    logic [IDX_W-1:0]   best_idx_next;

    always_comb begin
        cur_cnt       = snap_q[ptr_q];
        best_cnt_next = best_cnt_q;
        best_idx_next = best_idx_q;
`ifdef WINNER_SCAN_TIE_EN
        tie_next      = tie_r_q;
`endif
        if (cur_cnt > best_cnt_q) begin
            best_cnt_next = cur_cnt;
            best_idx_next = ptr_q;
`ifdef WINNER_SCAN_TIE_EN
            tie_next      = 1'b0;
`endif
        end
`ifdef WINNER_SCAN_TIE_EN
        else if (cur_cnt == best_cnt_q) begin
            // Keep the earlier (lower) index; only flag the tie.
            tie_next = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        snap_d       = snap_q;
        best_cnt_d   = best_cnt_q;
        best_idx_d   = best_idx_q;
        done_d       = 1'b0;
        winner_idx_d = winner_idx_q;
        winner_cnt_d = winner_cnt_q;
`ifdef WINNER_SCAN_TIE_EN
        tie_r_d      = tie_r_q;
        tie_d        = tie_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d     = tally_arr;
                    best_cnt_d = tally_arr[0];
                    best_idx_d = '0;
                    ptr_d      = IDX_W'(1);
`ifdef WINNER_SCAN_TIE_EN
                    tie_r_d    = 1'b0;
`endif
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                best_cnt_d = best_cnt_next;
                best_idx_d = best_idx_next;
`ifdef WINNER_SCAN_TIE_EN
                tie_r_d    = tie_next;
`endif
                if (ptr_q == LAST_PTR) begin
                    // ptr stays at the last candidate; it never wraps.
                    state_d      = DONE;
                    done_d       = 1'b1;
                    winner_idx_d = best_idx_next;
                    winner_cnt_d = best_cnt_next;
`ifdef WINNER_SCAN_TIE_EN
                    tie_d        = tie_next;
`endif
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            for (int k = 0; k < NUM_CAND; k++) begin
                snap_q[k] <= '0;
            end
            best_cnt_q   <= '0;
            best_idx_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            winner_idx_q <= '0;
            winner_cnt_q <= '0;
`ifdef WINNER_SCAN_TIE_EN
            tie_r_q      <= 1'b0;
            tie_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            snap_q       <= snap_d;
            best_cnt_q   <= best_cnt_d;
            best_idx_q   <= best_idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            winner_idx_q <= winner_idx_d;
            winner_cnt_q <= winner_cnt_d;
`ifdef WINNER_SCAN_TIE_EN
            tie_r_q      <= tie_r_d;
            tie_q        <= tie_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign winner_idx = winner_idx_q;
    assign winner_cnt = winner_cnt_q;
`ifdef WINNER_SCAN_TIE_EN
    assign tie        = tie_q;
`else
    assign tie        = 1'b0;
`endif

endmodule

// File: tb/tb_winner_scan.sv
// ---------------------------------------------------------------------------
// tb_winner_scan
//   Self-checking bench for winner_scan (NUM_CAND=4, CNT_W=4). Directed
//   cases plus randomized tallies are compared against a reference model
//   that picks the maximum, its first index and whether it occurs twice.
// ---------------------------------------------------------------------------
module tb_winner_scan;

    localparam int N  = 4;
    localparam int CW = 4;
    localparam int IW = 2;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [N*CW-1:0] tally;
    logic            busy;
    logic            done;
    logic [IW-1:0]   winner_idx;
    logic [CW-1:0]   winner_cnt;
    logic            tie;

    int checks   = 0;
    int failures = 0;

    winner_scan #(.NUM_CAND(N), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .tally      (tally),
        .busy       (busy),
        .done       (done),
        .winner_idx (winner_idx),
        .winner_cnt (winner_cnt),
        .tie        (tie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [N*CW-1:0] pack(input int v [N]);
        logic [N*CW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*CW +: CW] = v[k][CW-1:0];
        return r;
    endfunction

    // Reference: winner is the maximum, first index holding it; a tie
    // exists when the maximum occurs more than once.
    task automatic model(input int v [N], output int idx, output int cnt, output int t);
        int occurrences;
        cnt = v[0];
        for (int k = 1; k < N; k++) if (v[k] > cnt) cnt = v[k];
        idx = -1;
        occurrences = 0;
        for (int k = 0; k < N; k++) begin
            if (v[k] == cnt) begin
                occurrences++;
                if (idx < 0) idx = k;
            end
        end
`ifdef WINNER_SCAN_TIE_EN
        t = (occurrences > 1) ? 1 : 0;
`else
        t = 0;
`endif
    endtask

    // Runs one scan. With disturb set, start is pulsed again and tally is
    // overwritten with all-9s during the scan; the snapshot must win.
    task automatic run_scan(input string name, input int v [N], input bit disturb);
        int exp_idx, exp_cnt, exp_tie;
        int k;
        int nines [N];
        model(v, exp_idx, exp_cnt, exp_tie);
        for (int i = 0; i < N; i++) nines[i] = 9;
        @(negedge clk);
        tally = pack(v);
        start = 1'b1;
        @(posedge clk);            // E0
        @(negedge clk);
        start = 1'b0;
        k = 0;
        check({name, ".busy_after_start"}, int'(busy), 1);
        if (disturb) begin
            start = 1'b1;
            tally = pack(nines);
        end
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
            if (disturb && k == 1) start = 1'b0;
        end
        start = 1'b0;
        check({name, ".done_latency"}, k, N - 1);
        check({name, ".winner_idx"}, int'(winner_idx), exp_idx);
        check({name, ".winner_cnt"}, int'(winner_cnt), exp_cnt);
        check({name, ".tie"}, int'(tie), exp_tie);
        check({name, ".busy_in_done"}, int'(busy), 1);
        @(negedge clk);            // after E(N)
        check({name, ".done_pulse_width"}, int'(done), 0);
        check({name, ".busy_fall"}, int'(busy), 0);
        @(negedge clk);
        check({name, ".idle_no_restart"}, int'(busy), 0);
        check({name, ".idx_hold"}, int'(winner_idx), exp_idx);
        check({name, ".cnt_hold"}, int'(winner_cnt), exp_cnt);
        $display("scan %s tally={%0d,%0d,%0d,%0d} idx=%0d cnt=%0d tie=%0d",
                 name, v[0], v[1], v[2], v[3], winner_idx, winner_cnt, tie);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".busy"}, int'(busy), 0);
        check({name, ".done"}, int'(done), 0);
        check({name, ".idx"}, int'(winner_idx), 0);
        check({name, ".cnt"}, int'(winner_cnt), 0);
        check({name, ".tie"}, int'(tie), 0);
    endtask

    initial begin
        int v [N];
        int seen_done;
        rst_n = 1'b0;
        start = 1'b0;
        tally = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        v = '{3, 7, 2, 5};    run_scan("basic", v, 1'b0);
        v = '{5, 5, 1, 0};    run_scan("tie01", v, 1'b0);
        v = '{2, 9, 9, 15};   run_scan("tie_cleared", v, 1'b0);
        v = '{0, 0, 0, 0};    run_scan("all_zero", v, 1'b0);
        v = '{15, 14, 13, 12}; run_scan("descending", v, 1'b0);
        v = '{1, 2, 3, 4};    run_scan("disturbed", v, 1'b1);

        // Reset during scan cycle 2: outputs clear at once, no done pulse.
        v = '{8, 3, 12, 1};
        @(negedge clk);
        tally = pack(v);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midscan_reset");
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check("midscan_reset.no_done", seen_done, 0);
        check("midscan_reset.idle_busy", int'(busy), 0);
        v = '{0, 6, 6, 1};    run_scan("after_reset", v, 1'b0);

        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < N; k++) v[k] = int'($urandom_range(0, 15));
            if (r % 4 == 0) v[$urandom_range(0, 3)] = v[$urandom_range(0, 3)];
            run_scan($sformatf("rand%0d", r), v, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
